approx_booth_seq_mult: RTL and testbench
========================================

# approx_booth_seq_mult

- Sequential radix-4 Booth multiplier for signed N-bit operands, such as the 24-bit significands in the FP32 datapath.
- Generates one partial-product row per clock and accumulates it into a 2N-bit product.
- The lowest APPROX_ROWS rows can use the simplified approximate encoding, selected per transaction; all other rows are exact Booth.
- Sits between operand unpacking and normalisation in the FP multiply path, with valid/ready handshakes on both sides.

## Interface
- N, 24: operand width; must be even and ≥ 4.
- APPROX_ROWS, 6: number of low-order Booth rows (index 0..APPROX_ROWS-1) eligible for approximation; range 0..N/2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- multiplicand  in  N  signed A.
- multiplier  in  N  signed B.
- approx_mode  in  1  request approximate low rows for this transaction.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2N  signed A×B; exact or approximate per the captured mode.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture A, B and approx_mode, clear the accumulator, set row = 0, go to RUN.
- RUN:
  - Each cycle, add the sign-extended pp_row(row) << 2·row to the accumulator, then row++.
  - On the edge that processes row = N/2-1, go to DONE and set out_valid.
- DONE:
  - product and out_valid are held stable.
  - On out_ready, go to IDLE and clear out_valid. product keeps its last value.
- in_ready is 0 in RUN and DONE. in_valid is ignored there; there is no overlap of transactions.
- Booth group for row i is {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0.
- Exact row encoding:
  - 000 and 111 → 0.
  - 001 and 010 → +A.
  - 011 → +2A.
  - 100 → −2A.
  - 101 and 110 → −A.
- Approximate row: pp = B[2i-1] ? +A : 0. It applies only when the captured approx_mode = 1 and i < APPROX_ROWS.
- Width rules:
  - Partial product is N+2 bits signed, to hold ±2A with A = −2^(N−1).
  - The accumulator is 2N bits, modulo 2^(2N).
- Reset values: state IDLE, out_valid 0, product 0, busy 0, row 0, internal accumulator 0. in_ready reads 1 from the first cycle after reset.
- Reset mid-operation: the next edge with rst_n = 0 aborts the transaction. All outputs take their reset values and no partial result is emitted.

## Timing
- Accept edge is T. Rows are processed on edges T+1 … T+N/2. out_valid is high from edge T+N/2, i.e. 12 cycles for N = 24.
- The earliest next accept is the edge after the out_valid && out_ready edge. Throughput is one product per N/2+2 cycles when there is no back-pressure.
- No combinational path exists from any input to any output except in_ready/busy, which are decoded from state only.

## Configuration
- APPROX_BOOTH_EN defined:
  - approx_mode is honoured.
  - Rows below APPROX_ROWS use approximate encoding when it is captured as 1.
- APPROX_BOOTH_EN undefined:
  - All rows are exact and approx_mode is ignored (not captured).
  - Approximation logic is removed, and product always equals exact A×B.

## Structure
- Shared package approx_mult_pkg:
  - FSM state enum.
  - Booth group encoding constants (ZERO, POS1, POS2, NEG2, NEG1).
  - Helper function for the row count N/2.
- Sub-module booth_row_gen (combinational):
  - Inputs: A, 3-bit group, approx select.
  - Output: N+2-bit signed row.
  - Instantiated once and time-multiplexed over the rows.

## Test plan
1. Exact product: N=24, A=3, B=5, approx_mode=0 → out_valid 12 cycles after accept, product=15.
2. Signed exact product: A=−7 (24'hFFFFF9), B=6, approx_mode=0 → product=48'hFFFF_FFFF_FFD6 (−42).
3. Corner case: A=B=−2^23, exact → product=48'h4000_0000_0000.
4. Approximate mode:
   - With APPROX_BOOTH_EN: A=100, B=3, approx_mode=1, APPROX_ROWS=6 → product=400.
   - Without the macro, same stimulus → product=300.
5. Back-pressure: out_ready=0 for 5 cycles after out_valid, with in_valid pulsed in that window → product and out_valid stable, in_ready=0, pulsed operands never processed. On release, one handshake occurs, then in_ready=1.
6. Reset mid-operation: rst_n=0 for one cycle during row 5 → next edge out_valid=0, product=0, in_ready=1. A following transaction A=3, B=5 → 15.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// +--------------------------------------------------------------------------+
// | approx_mult_pkg : shared types, Booth encodings and row-count helper     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package approx_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG2 = 3'd3,
        BOOTH_NEG1 = 3'd4
    } booth_op_t;

    function automatic int booth_rows(input int n);
        return n / 2;
    endfunction

    // Group bits are {B[2i+1], B[2i], B[2i-1]}.
    function automatic booth_op_t booth_encode(input logic [2:0] grp);
        booth_op_t op;
        case (grp)
            3'b001, 3'b010: op = BOOTH_POS1;
            3'b011:         op = BOOTH_POS2;
            3'b100:         op = BOOTH_NEG2;
            3'b101, 3'b110: op = BOOTH_NEG1;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_row_gen.sv
// +--------------------------------------------------------------------------+
// | booth_row_gen : combinational radix-4 Booth partial-product row          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module booth_row_gen
    import approx_mult_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] a,
    input  logic [2:0]   group,
    input  logic         approx,
    output logic [N+1:0] row
);

    logic [N+1:0] a_x1;
    logic [N+1:0] a_x2;
    booth_op_t    op;

    assign a_x1 = {{2{a[N-1]}}, a};
    assign a_x2 = {a[N-1], a, 1'b0};
    assign op   = booth_encode(group);

    always_comb begin
        row = '0;
        if (approx) begin
            // Approximate row looks only at B[2i-1].
            row = group[0] ? a_x1 : '0;
        end else begin
            case (op)
                BOOTH_POS1: row = a_x1;
                BOOTH_POS2: row = a_x2;
                BOOTH_NEG2: row = ~a_x2 + 1'b1;
                BOOTH_NEG1: row = ~a_x1 + 1'b1;
                default:    row = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/approx_booth_seq_mult.sv
// +--------------------------------------------------------------------------+
// | approx_booth_seq_mult : sequential radix-4 Booth multiplier, one row per |
// | clock; APPROX_BOOTH_EN enables approximate low rows. Revision 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module approx_booth_seq_mult
    import approx_mult_pkg::*;
#(
    parameter int N           = 24,
    parameter int APPROX_ROWS = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           approx_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int ROWS  = booth_rows(N);
    localparam int ROW_W = $clog2(ROWS);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     a_hold;
    logic [N-1:0]     b_hold;
    logic [N:0]       b_ext;
    logic [ROW_W-1:0] row_idx;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   acc_next;
    logic [2:0]       group;
    logic             approx_sel;
    logic [N+1:0]     pp;
    logic [2*N-1:0]   pp_ext;
    logic             last_row;

    assign b_ext    = {b_hold, 1'b0};
    assign group    = b_ext[{row_idx, 1'b0} +: 3];
    assign last_row = (row_idx == ROW_W'(ROWS - 1));
    assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
    assign acc_next = acc + (pp_ext << {row_idx, 1'b0});

`ifdef APPROX_BOOTH_EN
    logic mode_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_hold <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            mode_hold <= approx_mode;
        end
    end

    assign approx_sel = mode_hold && ({1'b0, row_idx} < (ROW_W+1)'(APPROX_ROWS));
`else
    logic unused_approx_mode;

    assign unused_approx_mode = approx_mode;
    assign approx_sel         = 1'b0;
`endif

    booth_row_gen #(
        .N (N)
    ) u_row_gen (
        .a      (a_hold),
        .group  (group),
        .approx (approx_sel),
        .row    (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_row)  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_hold    <= '0;
            b_hold    <= '0;
            acc       <= '0;
            row_idx   <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_hold  <= multiplicand;
                        b_hold  <= multiplier;
                        acc     <= '0;
                        row_idx <= '0;
                    end
                end
                ST_RUN: begin
                    acc     <= acc_next;
                    row_idx <= row_idx + ROW_W'(1);
                    // Product register is separate so it survives the next accept.
                    if (last_row) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_approx_booth_seq_mult.sv
// +--------------------------------------------------------------------------+
// | tb_approx_booth_seq_mult : scoreboard bench for approx_booth_seq_mult    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_approx_booth_seq_mult;

    localparam int N           = 24;
    localparam int APPROX_ROWS = 6;
    localparam int ROWS        = N / 2;
`ifdef APPROX_BOOTH_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           approx_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    logic [2*N-1:0] exp_q[$];
    int             n_cmp  = 0;
    int             n_fail = 0;

    approx_booth_seq_mult #(
        .N           (N),
        .APPROX_ROWS (APPROX_ROWS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .approx_mode  (approx_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Booth digit identity d = -2*b[2i+1] + b[2i] + b[2i-1]; approximate rows keep b[2i-1].
    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic m);
        logic signed [2*N-1:0] as;
        logic signed [2*N-1:0] bs;
        logic signed [2*N-1:0] sum;
        logic [N:0]            bx;
        int                    d;
        as = {{N{a[N-1]}}, a};
        bs = {{N{b[N-1]}}, b};
        if (!(m && APPROX_EN)) return as * bs;
        bx  = {b, 1'b0};
        sum = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i < APPROX_ROWS) d = int'(bx[2*i]);
            else d = int'(bx[2*i]) + int'(bx[2*i+1]) - 2 * int'(bx[2*i+2]);
            sum = sum + ((as * (2*N)'(d)) <<< (2*i));
        end
        return sum;
    endfunction

    task automatic start_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
        int k;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        approx_mode  = m;
        in_valid     = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(a, b, m));
    endtask

    task automatic wait_result(input string tag, output logic [2*N-1:0] e);
        int k;
        k = 0;
        e = '0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_latency"}, 64'(k), 64'(ROWS));
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 64'(product), 64'(e));
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_ov_clear"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_txn(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic m);
        logic [2*N-1:0] e;
        start_txn(a, b, m);
        wait_result(tag, e);
        handshake(tag);
    endtask

    initial begin
        logic [2*N-1:0] e;
        int             seen;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        approx_mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_product", 64'(product), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        run_txn("exact_3x5", 24'd3, 24'd5, 1'b0);
        run_txn("signed_m7x6", 24'hFFFFF9, 24'd6, 1'b0);
        run_txn("corner_min", 24'h800000, 24'h800000, 1'b0);
        run_txn("approx_100x3", 24'd100, 24'd3, 1'b1);
        run_txn("approx_ignored_m0", 24'd100, 24'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("rand_%0d", i), N'($urandom), N'($urandom), 1'($urandom));
        end

        // Back-pressure with a stray operand pulse that must be ignored.
        start_txn(24'h123456, 24'hFEDCBA, 1'b0);
        wait_result("bp", e);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid     = (c == 2);
            multiplicand = 24'd7;
            multiplier   = 24'd9;
            @(posedge clk);
            #1;
            check_eq($sformatf("bp_ov_%0d", c), 64'(out_valid), 64'd1);
            check_eq($sformatf("bp_prod_%0d", c), 64'(product), 64'(e));
            check_eq($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
            check_eq($sformatf("bp_busy_%0d", c), 64'(busy), 64'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check_eq("bp_no_ghost", 64'(seen), 64'd0);

        // Reset during row 5 aborts the transaction.
        start_txn(24'd3, 24'd5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        check_eq("mid_rst_ov", 64'(out_valid), 64'd0);
        check_eq("mid_rst_prod", 64'(product), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        run_txn("after_rst_3x5", 24'd3, 24'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
